// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : 64x8 word store behind a 4-phase rd_req/wr_req handshake.
//               A request is latched in IDLE, optionally delayed by
//               WAIT_CYCLES wait states, and then completed on the edge that
//               enters ACK. ACK is held until both request lines drop.
//               Optional feature macro: MEM_WRITE_PROTECT_EN. When it is
//               defined, writes below PROT_LIMIT are refused and flagged
//               on err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] adr,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ack,
    output logic       busy,
    output logic       err
);

    // State encoding
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_ack  = 2'd2;

    localparam logic [2:0] c_wait_init  = 3'(WAIT_CYCLES);
    localparam bit         c_wait_zero  = (WAIT_CYCLES == 0);
    localparam logic [6:0] c_prot_limit = 7'(PROT_LIMIT);

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit c_protect_en = 1'b1;
`else
    localparam bit c_protect_en = 1'b0;
`endif

    logic [7:0] r_mem [64];

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [5:0] r_adr;
    logic       r_wr;
    logic [7:0] r_data;
    logic [7:0] r_data_out;
    logic       r_ack;
    logic       r_busy;
    logic       r_err;

    logic       w_start;
    logic       w_illegal;
    logic       w_wait_done;
    logic       w_enter_ack;
    logic [5:0] w_acc_adr;
    logic       w_acc_wr;
    logic [7:0] w_acc_data;
    logic       w_prot;
    logic       w_mem_we;
    logic       w_mem_re;

    // Decode the access that completes on this edge. With zero wait states the
    // access completes on the sampling edge itself, so the live inputs are
    // used; otherwise the values latched in IDLE are used.
    always_comb begin
        w_start     = (r_state == c_idle) && (rd_req ^ wr_req);
        w_illegal   = (r_state == c_idle) && rd_req && wr_req;
        w_wait_done = (r_state == c_wait) && (r_cnt == 3'd1);
        w_enter_ack = (w_start && c_wait_zero) || w_wait_done;
        w_acc_adr   = w_start ? adr     : r_adr;
        w_acc_wr    = w_start ? wr_req  : r_wr;
        w_acc_data  = w_start ? data_in : r_data;
        w_prot      = c_protect_en && w_acc_wr && ({1'b0, w_acc_adr} < c_prot_limit);
        // Reset gating keeps a held request from writing while rst_n is low.
        w_mem_we    = rst_n && w_enter_ack && w_acc_wr && !w_prot;
        w_mem_re    = w_enter_ack && !w_acc_wr;
    end

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_acc_adr] <= w_acc_data;
        end
    end

    // Handshake FSM with registered ack/busy/err and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_cnt      <= 3'd0;
            r_adr      <= 6'd0;
            r_wr       <= 1'b0;
            r_data     <= 8'h00;
            r_data_out <= 8'h00;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_start) begin
                        r_adr  <= adr;
                        r_wr   <= wr_req;
                        r_data <= data_in;
                        r_busy <= 1'b1;
                        if (c_wait_zero) begin
                            r_state <= c_ack;
                            r_ack   <= 1'b1;
                            r_cnt   <= 3'd0;
                            r_err   <= w_prot;
                        end else begin
                            r_state <= c_wait;
                            r_cnt   <= c_wait_init;
                        end
                    end
                end
                c_wait: begin
                    if (w_wait_done) begin
                        r_state <= c_ack;
                        r_ack   <= 1'b1;
                        r_cnt   <= 3'd0;
                        r_err   <= w_prot;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_ack: begin
                    if (!rd_req && !wr_req) begin
                        r_state <= c_idle;
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= 3'd0;
                end
            endcase
            if (w_mem_re) begin
                r_data_out <= r_mem[w_acc_adr];
            end
        end
    end

    assign data_out = r_data_out;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder. Four DUT
//               instances with WAIT_CYCLES = 0, 1, 3, 7 share clock and
//               reset; each task exercises one scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int WC [4] = '{0, 1, 3, 7};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] adr      [4];
    logic       rd_req   [4];
    logic       wr_req   [4];
    logic [7:0] data_in  [4];
    logic [7:0] data_out [4];
    logic       ack      [4];
    logic       busy     [4];
    logic       err      [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder #(
            .WAIT_CYCLES(WC[g]),
            .PROT_LIMIT (16)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .adr     (adr[g]),
            .rd_req  (rd_req[g]),
            .wr_req  (wr_req[g]),
            .data_in (data_in[g]),
            .data_out(data_out[g]),
            .ack     (ack[g]),
            .busy    (busy[g]),
            .err     (err[g])
        );
    end

    // Raise one request and count edges until ack; busy must be high while waiting.
    task automatic access(input int i, input logic wr, input logic [5:0] a,
                          input logic [7:0] d, output int edges);
        adr[i]     = a;
        data_in[i] = d;
        wr_req[i]  = wr;
        rd_req[i]  = ~wr;
        edges      = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (ack[i] !== 1'b1) begin
                n_total++;
                if (busy[i] !== 1'b1) $display("FAIL busy_wait dut%0d: busy=%b required 1", i, busy[i]);
                else n_pass++;
            end
        end while (ack[i] !== 1'b1 && edges < 20);
    endtask

    // Drop both request lines; the following edge returns to IDLE.
    task automatic release_req(input int i);
        rd_req[i] = 1'b0;
        wr_req[i] = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (ack[i] !== 1'b0) $display("FAIL release_ack dut%0d: ack=%b required 0", i, ack[i]);
        else n_pass++;
        n_total++;
        if (busy[i] !== 1'b0) $display("FAIL release_busy dut%0d: busy=%b required 0", i, busy[i]);
        else n_pass++;
        n_total++;
        if (err[i] !== 1'b0) $display("FAIL release_err dut%0d: err=%b required 0", i, err[i]);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || err[i] !== 1'b0 || data_out[i] !== 8'h00)
                $display("FAIL reset_outputs dut%0d: ack=%b busy=%b err=%b data_out=%h required 0/0/0/00",
                         i, ack[i], busy[i], err[i], data_out[i]);
            else n_pass++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (busy[1] !== 1'b0 || ack[1] !== 1'b0)
            $display("FAIL reset_idle: busy=%b ack=%b required 0/0", busy[1], ack[1]);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int e;
        access(1, 1'b1, 6'h20, 8'hA5, e);
        n_total++;
        if (e !== 2) $display("FAIL wr_latency: edges=%0d required 2", e);
        else n_pass++;
        n_total++;
        if (err[1] !== 1'b0) $display("FAIL wr_err: err=%b required 0", err[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h20, 8'h00, e);
        n_total++;
        if (e !== 2) $display("FAIL rd_latency: edges=%0d required 2", e);
        else n_pass++;
        n_total++;
        if (data_out[1] !== 8'hA5) $display("FAIL rd_data: data_out=%h required a5", data_out[1]);
        else n_pass++;
        release_req(1);
        // A write must not disturb the read data register.
        access(1, 1'b1, 6'h21, 8'h5A, e);
        release_req(1);
        n_total++;
        if (data_out[1] !== 8'hA5) $display("FAIL data_hold: data_out=%h required a5", data_out[1]);
        else n_pass++;
    endtask

    task automatic test_latency();
        int e;
        access(0, 1'b1, 6'h01, 8'h11, e);
        n_total++;
        if (e !== 1) $display("FAIL lat_w0_wr: edges=%0d required 1", e);
        else n_pass++;
        release_req(0);
        access(0, 1'b0, 6'h01, 8'h00, e);
        n_total++;
        if (e !== 1 || data_out[0] !== 8'h11)
            $display("FAIL lat_w0_rd: edges=%0d data_out=%h required 1/11", e, data_out[0]);
        else n_pass++;
        release_req(0);
        access(3, 1'b1, 6'h3F, 8'h99, e);
        n_total++;
        if (e !== 8) $display("FAIL lat_w7_wr: edges=%0d required 8", e);
        else n_pass++;
        release_req(3);
        access(3, 1'b0, 6'h3F, 8'h00, e);
        n_total++;
        if (e !== 8 || data_out[3] !== 8'h99)
            $display("FAIL lat_w7_rd: edges=%0d data_out=%h required 8/99", e, data_out[3]);
        else n_pass++;
        release_req(3);
    endtask

    task automatic test_address_bounds();
        int e;
        access(1, 1'b1, 6'h00, 8'h42, e);
        release_req(1);
        access(1, 1'b1, 6'h3F, 8'hC3, e);
        release_req(1);
        access(1, 1'b0, 6'h00, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'h42) $display("FAIL adr_low: data_out=%h required 42", data_out[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h3F, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'hC3) $display("FAIL adr_high: data_out=%h required c3", data_out[1]);
        else n_pass++;
        release_req(1);
    endtask

    task automatic test_hold_ack();
        int e;
        access(1, 1'b0, 6'h20, 8'h00, e);
        n_total++;
        if (e !== 2 || data_out[1] !== 8'hA5)
            $display("FAIL hold_first: edges=%0d data_out=%h required 2/a5", e, data_out[1]);
        else n_pass++;
        adr[1] = 6'h21;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (ack[1] !== 1'b1 || busy[1] !== 1'b1)
                $display("FAIL hold_ack cycle%0d: ack=%b busy=%b required 1/1", k, ack[1], busy[1]);
            else n_pass++;
        end
        n_total++;
        if (data_out[1] !== 8'hA5) $display("FAIL hold_single: data_out=%h required a5", data_out[1]);
        else n_pass++;
        release_req(1);
    endtask

    task automatic test_latch();
        int e;
        adr[1]     = 6'h22;
        data_in[1] = 8'h33;
        wr_req[1]  = 1'b1;
        @(posedge clk); #1;
        adr[1]     = 6'h23;
        data_in[1] = 8'hEE;
        @(posedge clk); #1;
        n_total++;
        if (ack[1] !== 1'b1) $display("FAIL latch_ack: ack=%b required 1", ack[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h22, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'h33) $display("FAIL latch_data: data_out=%h required 33", data_out[1]);
        else n_pass++;
        release_req(1);
    endtask

    task automatic test_illegal();
        int e;
        access(1, 1'b1, 6'h30, 8'h3C, e);
        release_req(1);
        adr[1]     = 6'h30;
        data_in[1] = 8'h00;
        rd_req[1]  = 1'b1;
        wr_req[1]  = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (err[1] !== 1'b1 || ack[1] !== 1'b0 || busy[1] !== 1'b0)
            $display("FAIL illegal_pulse: err=%b ack=%b busy=%b required 1/0/0", err[1], ack[1], busy[1]);
        else n_pass++;
        rd_req[1] = 1'b0;
        wr_req[1] = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (err[1] !== 1'b0) $display("FAIL illegal_width: err=%b required 0", err[1]);
        else n_pass++;
        access(1, 1'b0, 6'h30, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'h3C) $display("FAIL illegal_mem: data_out=%h required 3c", data_out[1]);
        else n_pass++;
        release_req(1);
    endtask

    task automatic test_reset_in_wait();
        int e;
        access(2, 1'b1, 6'h10, 8'h55, e);
        n_total++;
        if (e !== 4) $display("FAIL w3_latency: edges=%0d required 4", e);
        else n_pass++;
        release_req(2);
        access(2, 1'b0, 6'h10, 8'h00, e);
        n_total++;
        if (data_out[2] !== 8'h55) $display("FAIL w3_read: data_out=%h required 55", data_out[2]);
        else n_pass++;
        release_req(2);
        adr[2]     = 6'h10;
        data_in[2] = 8'h77;
        wr_req[2]  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++;
        if (busy[2] !== 1'b1 || ack[2] !== 1'b0)
            $display("FAIL rstwait_pre: busy=%b ack=%b required 1/0", busy[2], ack[2]);
        else n_pass++;
        wr_req[2] = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_total++;
        if (ack[2] !== 1'b0 || busy[2] !== 1'b0 || data_out[2] !== 8'h00)
            $display("FAIL rstwait_outputs: ack=%b busy=%b data_out=%h required 0/0/00",
                     ack[2], busy[2], data_out[2]);
        else n_pass++;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        access(2, 1'b0, 6'h10, 8'h00, e);
        n_total++;
        if (e !== 4 || data_out[2] !== 8'h55)
            $display("FAIL rstwait_mem: edges=%0d data_out=%h required 4/55", e, data_out[2]);
        else n_pass++;
        release_req(2);
    endtask

    task automatic test_write_protect();
        int e;
        access(1, 1'b1, 6'h05, 8'hFF, e);
        n_total++;
        if (e !== 2) $display("FAIL prot_latency: edges=%0d required 2", e);
        else n_pass++;
`ifdef MEM_WRITE_PROTECT_EN
        n_total++;
        if (err[1] !== 1'b1) $display("FAIL prot_err: err=%b required 1", err[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h05, 8'h00, e);
        n_total++;
        if (data_out[1] === 8'hFF) $display("FAIL prot_mem: data_out=%h required not ff", data_out[1]);
        else n_pass++;
        release_req(1);
`else
        n_total++;
        if (err[1] !== 1'b0) $display("FAIL noprot_err: err=%b required 0", err[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h05, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'hFF) $display("FAIL noprot_mem: data_out=%h required ff", data_out[1]);
        else n_pass++;
        release_req(1);
`endif
        access(1, 1'b1, 6'h10, 8'hAB, e);
        n_total++;
        if (err[1] !== 1'b0) $display("FAIL limit_err: err=%b required 0", err[1]);
        else n_pass++;
        release_req(1);
        access(1, 1'b0, 6'h10, 8'h00, e);
        n_total++;
        if (data_out[1] !== 8'hAB) $display("FAIL limit_mem: data_out=%h required ab", data_out[1]);
        else n_pass++;
        release_req(1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            adr[i]     = 6'h00;
            rd_req[i]  = 1'b0;
            wr_req[i]  = 1'b0;
            data_in[i] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_latency();
        test_address_bounds();
        test_hold_ack();
        test_latch();
        test_illegal();
        test_reset_in_wait();
        test_write_protect();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
